// File: rtl/tally_pkg.sv
// Shared types and constants for the winner tally stage.
package tally_pkg;

    typedef enum logic [0:0] {
        StAccum,
        StDump
    } tally_state_e;

    // Bit positions inside the sticky err vector.
    localparam int unsigned ErrUnderflow = 0;
    localparam int unsigned ErrBadLabel  = 1;
    localparam int unsigned ErrOverrun   = 2;

    localparam int unsigned CntBits = 16;
    typedef logic [CntBits-1:0] cnt_t;

endpackage

// File: rtl/label_fifo.sv
// Small synchronous FIFO holding test labels until their column result arrives.
module label_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates the full and empty cases.
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= din;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/winner_tally.sv
// Confusion-matrix tally of column winners against test labels, with
// handshaked matrix readout and a purity numerator computed during the dump.
module winner_tally
    import tally_pkg::*;
#(
    parameter int unsigned NEURONS     = 16,
    parameter int unsigned CLASSES     = 10,
    parameter int unsigned CNT_BITS    = CntBits,
    parameter int unsigned LABEL_BITS  = 4,
    parameter int unsigned LFIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                label_valid,
    input  logic [LABEL_BITS-1:0]               label,
    output logic                                label_ready,
    input  logic                                col_valid,
    input  logic                                col_no_winner,
    input  logic [$clog2(NEURONS)-1:0]          col_winner,
    input  logic                                dump_req,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(NEURONS)-1:0]          out_neuron,
    output logic [LABEL_BITS-1:0]               out_class,
    output logic [CNT_BITS-1:0]                 out_count,
    output logic                                out_last,
    output logic [CNT_BITS-1:0]                 images,
    output logic [CNT_BITS-1:0]                 spikes,
    output logic [CNT_BITS+$clog2(NEURONS)-1:0] purity_num,
    output logic                                purity_valid,
    output logic [2:0]                          err
);

    localparam int unsigned NW = $clog2(NEURONS);
    localparam int unsigned PW = CNT_BITS + NW;
    localparam logic [NW-1:0]         LastRow   = NW'(NEURONS - 1);
    localparam logic [LABEL_BITS-1:0] LastClass = LABEL_BITS'(CLASSES - 1);

    tally_state_e state_q, state_d;

    logic                  fifo_full, fifo_empty;
    logic [LABEL_BITS-1:0] fifo_head;

    logic [CNT_BITS-1:0]   cell_q [NEURONS][CLASSES];
    logic [CNT_BITS-1:0]   images_q, spikes_q;
    logic [2:0]            err_q;

    logic [NW-1:0]         row_q;
    logic [LABEL_BITS-1:0] col_q;
    logic [CNT_BITS-1:0]   rowmax_q;
    logic [PW-1:0]         purity_q;
    logic                  purity_valid_q;

    logic                  in_accum, in_dump;
    logic                  accum_hit, label_ok;
    logic                  hs, row_end, dump_end;
    logic [CNT_BITS-1:0]   cur_count, row_best;

    assign in_accum  = (state_q == StAccum);
    assign in_dump   = (state_q == StDump);
    assign accum_hit = in_accum && col_valid;
    // Compare one bit wider so CLASSES == 2**LABEL_BITS still works.
    assign label_ok  = ({1'b0, fifo_head} < (LABEL_BITS + 1)'(CLASSES));

    assign hs        = out_valid && out_ready;
    assign row_end   = (col_q == LastClass);
    assign dump_end  = hs && row_end && (row_q == LastRow);
    assign cur_count = cell_q[row_q][col_q];
    assign row_best  = (cur_count > rowmax_q) ? cur_count : rowmax_q;

    label_fifo #(
        .DEPTH (LFIFO_DEPTH),
        .WIDTH (LABEL_BITS)
    ) u_label_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (label_valid),
        .din   (label),
        .pop   (accum_hit),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (dump_req) state_d = StDump;
            StDump:  if (dump_end) state_d = StAccum;
            default: state_d = StAccum;
        endcase
        if (clear) state_d = StAccum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulation: matrix and totals, all saturating. Frozen during a dump.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int n = 0; n < NEURONS; n++) begin
                for (int c = 0; c < CLASSES; c++) begin
                    cell_q[n][c] <= '0;
                end
            end
            images_q <= '0;
            spikes_q <= '0;
            err_q    <= '0;
        end else begin
            if (accum_hit) begin
                if (fifo_empty) begin
                    err_q[ErrUnderflow] <= 1'b1;
                end else begin
                    if (images_q != '1) images_q <= images_q + CNT_BITS'(1);
                    if (!label_ok) begin
                        err_q[ErrBadLabel] <= 1'b1;
                    end else if (!col_no_winner) begin
                        if (spikes_q != '1) spikes_q <= spikes_q + CNT_BITS'(1);
                        if (cell_q[col_winner][fifo_head] != '1) begin
                            cell_q[col_winner][fifo_head] <=
                                cell_q[col_winner][fifo_head] + CNT_BITS'(1);
                        end
                    end
                end
            end
            if (in_dump && col_valid) begin
                err_q[ErrOverrun] <= 1'b1;
            end
        end
    end

    // Dump walker and purity accumulation over accepted entries.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row_q          <= '0;
            col_q          <= '0;
            rowmax_q       <= '0;
            purity_q       <= '0;
            purity_valid_q <= 1'b0;
        end else begin
            purity_valid_q <= dump_end;
            if (in_accum && dump_req) begin
                row_q    <= '0;
                col_q    <= '0;
                rowmax_q <= '0;
                purity_q <= '0;
            end else if (hs) begin
                if (row_end) begin
                    col_q    <= '0;
                    row_q    <= (row_q == LastRow) ? '0 : row_q + NW'(1);
                    rowmax_q <= '0;
                    purity_q <= purity_q + PW'(row_best);
                end else begin
                    col_q    <= col_q + LABEL_BITS'(1);
                    rowmax_q <= row_best;
                end
            end
        end
    end

    assign label_ready  = !fifo_full;
    assign busy         = in_dump;
    assign out_valid    = in_dump;
    assign out_neuron   = row_q;
    assign out_class    = col_q;
    assign out_count    = in_dump ? cur_count : '0;
    assign out_last     = in_dump && row_end && (row_q == LastRow);
    assign images       = images_q;
    assign spikes       = spikes_q;
    assign purity_num   = purity_q;
    assign purity_valid = purity_valid_q;
    assign err          = err_q;

endmodule
